// File: rtl/seq_arb_mux_4b_5to1_pkg.sv
// ---------------------------------------------------------------------------
// MuxPkg
// Shared widths, types and helpers for the 5-to-1 round-robin arbitrated mux.
//   NBITS   : payload width (4)
//   NINPUTS : number of producer channels (5)
//   msg_t   : payload type
//   sel_t   : source index type, legal range 0..NINPUTS-1
//   rr_next : mod-5 increment of a source index
//   oh_to_sel : one-hot grant vector to source index
// ---------------------------------------------------------------------------
package MuxPkg;

   localparam int NBITS   = 4;
   localparam int NINPUTS = 5;

   typedef logic [NBITS-1:0] msg_t;
   typedef logic [2:0]       sel_t;

   // Index 4 wraps to 0; codes 5..7 are never produced.
   function automatic sel_t rr_next(input sel_t s);
      return (s >= sel_t'(NINPUTS - 1)) ? sel_t'(0) : s + sel_t'(1);
   endfunction

   function automatic sel_t oh_to_sel(input logic [NINPUTS-1:0] oh);
      sel_t r;
      r = '0;
      for (int k = 0; k < NINPUTS; k++) begin
         if (oh[k]) r = sel_t'(k);
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_arb_mux_4b_5to1_arb.sv
// ---------------------------------------------------------------------------
// rr_arb_5
// Five-way round-robin arbiter. The search for a requester starts at the
// priority pointer and wraps mod 5; the pointer then moves to the input just
// after the winner, so a continuously requesting set is served in strict
// rotation.
//   clk   : clock
//   reset : synchronous active-high, returns priority to input 0
//   req   : request vector, bit k = input k wants service
//   en    : grant permitted this cycle (downstream has room)
//   grant : one-hot winner, all zero when en is low or nobody requests
// ---------------------------------------------------------------------------
module rr_arb_5
   import MuxPkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NINPUTS-1:0] req,
   input  logic               en,
   output logic [NINPUTS-1:0] grant
);

   sel_t r_ptr;
   sel_t w_idx;
   logic w_found;

   // Walk the five candidates starting at the pointer; first requester wins.
   always_comb begin
      grant   = '0;
      w_idx   = r_ptr;
      w_found = 1'b0;
      for (int i = 0; i < NINPUTS; i++) begin
         if (!w_found && req[w_idx]) begin
            grant[w_idx] = 1'b1;
            w_found      = 1'b1;
         end
         w_idx = rr_next(w_idx);
      end
      if (!en) grant = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (en && (|req)) begin
         r_ptr <= rr_next(oh_to_sel(grant));
      end
   end

endmodule

// File: rtl/seq_arb_mux_4b_5to1.sv
// ---------------------------------------------------------------------------
// seq_arb_mux_4b_5to1
// Collects 4-bit messages from five val/rdy producers onto one registered
// val/rdy output, tagging each with its 3-bit source index so a downstream
// 1-to-5 demux can steer it back out using out_sel.
//   clk      : clock
//   reset    : synchronous active-high reset
//   in0..in4 : per-channel payloads
//   in_val   : per-channel valid
//   in_rdy   : per-channel accept, one-hot or zero
//   out      : registered payload
//   out_sel  : registered source index 0..4
//   out_val  : output register holds a message
//   out_rdy  : consumer accepts the output this cycle
// ---------------------------------------------------------------------------
module seq_arb_mux_4b_5to1
   import MuxPkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NBITS-1:0]   in0,
   input  logic [NBITS-1:0]   in1,
   input  logic [NBITS-1:0]   in2,
   input  logic [NBITS-1:0]   in3,
   input  logic [NBITS-1:0]   in4,
   input  logic [NINPUTS-1:0] in_val,
   output logic [NINPUTS-1:0] in_rdy,
   output logic [NBITS-1:0]   out,
   output logic [2:0]         out_sel,
   output logic               out_val,
   input  logic               out_rdy
);

   msg_t                r_out_p1;
   sel_t                r_sel_p1;
   logic                r_vld_p1;

   logic                w_can_accept;
   logic                w_en;
   logic [NINPUTS-1:0]  w_grant;
   sel_t                w_sel_p0;
   msg_t                w_msg_p0;

   // The register may refill in the same cycle it drains.
   assign w_can_accept = !r_vld_p1 || out_rdy;
   // Holding grants off during reset keeps in_rdy at zero while reset is high.
   assign w_en         = w_can_accept && !reset;

   rr_arb_5 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (in_val),
      .en    (w_en),
      .grant (w_grant)
   );

   assign in_rdy   = w_grant;
   assign w_sel_p0 = oh_to_sel(w_grant);

   always_comb begin
      w_msg_p0 = '0;
      unique case (w_sel_p0)
         3'd0:    w_msg_p0 = in0;
         3'd1:    w_msg_p0 = in1;
         3'd2:    w_msg_p0 = in2;
         3'd3:    w_msg_p0 = in3;
         3'd4:    w_msg_p0 = in4;
         default: w_msg_p0 = '0;
      endcase
   end

   // ---- stage p0 -> p1: output register ----
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_p1 <= '0;
         r_sel_p1 <= '0;
         r_vld_p1 <= 1'b0;
      end else if (|w_grant) begin
         r_out_p1 <= w_msg_p0;
         r_sel_p1 <= w_sel_p0;
         r_vld_p1 <= 1'b1;
      end else if (r_vld_p1 && out_rdy) begin
         r_vld_p1 <= 1'b0;
      end
   end

   assign out     = r_out_p1;
   assign out_sel = r_sel_p1;
   assign out_val = r_vld_p1;

endmodule
